// File: rtl/axi4l_lsu_master.sv
// AXI4-Lite initiator for the LSU: one request in, exactly one AR/R or AW/W/B
// transaction out, then a single response (read data + error flag) to the core.
module axi4l_lsu_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   // core request port
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   // core response port
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   // AXI read address / data
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   // AXI write address / data / response
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;

   logic [2:0] state_reg;
   logic       aw_done_reg;
   logic       w_done_reg;
   logic       aw_fire;
   logic       w_fire;

   assign aw_fire   = awvalid && awready;
   assign w_fire    = wvalid && wready;
   // Gated by reset so the core never sees an accept while reset is held.
   assign req_ready = (state_reg == IDLE) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         araddr      <= '0;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         awaddr      <= '0;
         awvalid     <= 1'b0;
         wdata       <= '0;
         wstrb       <= '0;
         wvalid      <= 1'b0;
         bready      <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     awaddr    <= req_addr;
                     wdata     <= req_wdata;
                     wstrb     <= req_wstrb;
                     awvalid   <= 1'b1;
                     wvalid    <= 1'b1;
                     state_reg <= WR_REQ;
                  end else begin
                     araddr    <= req_addr;
                     arvalid   <= 1'b1;
                     state_reg <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid   <= 1'b0;
                  rready    <= 1'b1;
                  state_reg <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  resp_rdata <= rdata;
                  resp_err   <= (rresp != 2'b00);
                  rready     <= 1'b0;
                  resp_valid <= 1'b1;
                  state_reg  <= RESP;
               end
            end
            WR_REQ: begin
               // AW and W complete independently; each valid drops once and stays low.
               if (aw_fire) begin
                  awvalid     <= 1'b0;
                  aw_done_reg <= 1'b1;
               end
               if (w_fire) begin
                  wvalid     <= 1'b0;
                  w_done_reg <= 1'b1;
               end
               if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
                  bready      <= 1'b1;
                  state_reg   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  resp_rdata <= '0;
                  resp_err   <= (bresp != 2'b00);
                  bready     <= 1'b0;
                  resp_valid <= 1'b1;
                  state_reg  <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4l_lsu_master.sv
// Bench for axi4l_lsu_master: configurable-latency AXI responder, scoreboarded
// core requests, and directed checks on handshake timing and reset abort.
module tb_axi4l_lsu_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   axi4l_lsu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // responder configuration and observations
   int          cfg_ar_lat = 0, cfg_r_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0;
   logic [31:0] cfg_rdata = '0;
   logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
   int          ar_count = 0, aw_count = 0, w_count = 0;
   logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, w_data_seen = '0;
   logic [3:0]  w_strb_seen = '0;
   int          aw_last = 0, w_last = 0, b_rise = 0;
   int          last_hs = 0;

   // AXI responder: drives at negedge; a handshake happens at the next posedge
   // when the valid/ready pair seen here is both high (DUT outputs are stable).
   initial begin
      bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
      bit r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0, bready_prev = 0;
      int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0; bready_prev = 0;
            ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
         end else begin
            if (ar_hs) begin r_pend = 1; r_wait = 0; end
            if (r_hs) rvalid = 0;
            if (aw_hs) aw_seen = 1;
            if (w_hs) w_seen = 1;
            if (aw_seen && w_seen) begin b_pend = 1; b_wait = 0; aw_seen = 0; w_seen = 0; end
            if (b_hs) bvalid = 0;

            arready = 0;
            if (arvalid) begin if (ar_wait >= cfg_ar_lat) arready = 1; else ar_wait++; end
            else ar_wait = 0;
            awready = 0;
            if (awvalid) begin if (aw_wait >= cfg_aw_lat) awready = 1; else aw_wait++; end
            else aw_wait = 0;
            wready = 0;
            if (wvalid) begin if (w_wait >= cfg_w_lat) wready = 1; else w_wait++; end
            else w_wait = 0;

            if (r_pend) begin
               if (r_wait >= cfg_r_lat) begin
                  rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_pend = 0;
               end else r_wait++;
            end
            if (b_pend) begin
               if (b_wait >= cfg_b_lat) begin
                  bvalid = 1; bresp = cfg_bresp; b_pend = 0;
               end else b_wait++;
            end

            ar_hs = arvalid && arready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            r_hs  = rvalid && rready;
            b_hs  = bvalid && bready;
            if (ar_hs) begin ar_count++; ar_addr_seen = araddr; end
            if (aw_hs) begin aw_count++; aw_addr_seen = awaddr; end
            if (w_hs)  begin w_count++; w_data_seen = wdata; w_strb_seen = wstrb; end
            if (awvalid) aw_last = cyc;
            if (wvalid) w_last = cyc;
            if (bready && !bready_prev) b_rise = cyc;
            bready_prev = bready;
         end
      end
   end

   // One core transaction: request, wait for response, optionally stall, consume.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [31:0] exp_rdata, input bit exp_err,
                         input int hold, input int exp_lat, input bit b2b, output int acc);
      int   t;
      int   ar0, aw0, w0;
      exp_t e;
      @(negedge clk);
      resp_ready = 0;
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
      acc = cyc;
      t = 0;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 0;
         return;
      end
      acc = cyc;
      ar0 = ar_count; aw0 = aw_count; w0 = w_count;
      if (b2b) chk("b2b_gap", 64'(acc - last_hs), 1);
      e.rdata = we ? 32'h0 : exp_rdata;
      e.err   = exp_err;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 0;
      t = 0;
      while (!resp_valid && t < 100) begin @(negedge clk); t++; end
      if (!resp_valid) begin
         chk("resp_timeout", 0, 1);
         void'(sb.pop_front());
         return;
      end
      chk("latency", 64'(cyc - acc), 64'(exp_lat));
      if (we) begin
         chk("aw_count", 64'(aw_count - aw0), 1);
         chk("w_count", 64'(w_count - w0), 1);
         chk("ar_count_wr", 64'(ar_count - ar0), 0);
         chk("awaddr", aw_addr_seen, addr);
         chk("wdata", w_data_seen, wd);
         chk("wstrb", w_strb_seen, strb);
      end else begin
         chk("ar_count", 64'(ar_count - ar0), 1);
         chk("aw_count_rd", 64'(aw_count - aw0), 0);
         chk("araddr", ar_addr_seen, addr);
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", resp_valid, 1);
         chk("hold_rdata", resp_rdata, e.rdata);
         chk("hold_err", resp_err, e.err);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_axi_valid", {arvalid, awvalid, wvalid}, 3'b000);
         @(negedge clk);
      end
      chk("resp_valid", resp_valid, 1);
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("resp_rdata", resp_rdata, e.rdata);
         chk("resp_err", resp_err, e.err);
      end
      $display("txn we=%0b addr=%h rdata=%h err=%0b lat=%0d", we, addr, resp_rdata, resp_err, cyc - acc);
      resp_ready = 1;
      last_hs = cyc;
   endtask

   initial begin
      int acc;
      int t;
      reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 7'b0);
      chk("rst_regs", {araddr, awaddr}, 64'h0);
      chk("rst_data", {wdata, resp_rdata}, 64'h0);
      chk("rst_wstrb", wstrb, 4'h0);
      reset = 0;

      // late AR ready, delayed R
      cfg_ar_lat = 3; cfg_r_lat = 2; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
      do_req(0, 32'ha000_2000, 32'h0, 4'h0, 32'h1234_5678, 0, 0, 8, 0, acc);

      // AW accepted immediately, W five cycles later
      cfg_ar_lat = 0; cfg_r_lat = 0; cfg_aw_lat = 0; cfg_w_lat = 5; cfg_b_lat = 0; cfg_bresp = 2'b00;
      do_req(1, 32'ha000_2004, 32'hdead_beef, 4'hf, 32'h0, 0, 0, 8, 1, acc);
      chk("aw_last", 64'(aw_last - acc), 1);
      chk("w_last", 64'(w_last - acc), 6);
      chk("b_rise", 64'(b_rise - acc), 7);

      // error responses
      cfg_w_lat = 0; cfg_rdata = 32'h0000_55aa; cfg_rresp = 2'b10;
      do_req(0, 32'h0200_0000, 32'h0, 4'h0, 32'h0000_55aa, 1, 0, 3, 1, acc);
      cfg_rresp = 2'b00; cfg_bresp = 2'b11;
      do_req(1, 32'h1000_0000, 32'h0000_0041, 4'h1, 32'h0, 1, 0, 3, 1, acc);
      cfg_bresp = 2'b00;

      // core stalls the response for 4 cycles
      cfg_rdata = 32'h0bad_f00d;
      do_req(0, 32'ha000_0010, 32'h0, 4'h0, 32'h0bad_f00d, 0, 4, 3, 1, acc);

      // reset after AW handshake, while W is still pending
      cfg_aw_lat = 0; cfg_w_lat = 10;
      @(negedge clk);
      resp_ready = 0;
      req_valid = 1; req_we = 1; req_addr = 32'ha000_3000; req_wdata = 32'hcafe_f00d; req_wstrb = 4'h3;
      t = 0;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      chk("rst_test_accept", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      chk("rst_test_aw_done", {awvalid, wvalid}, 2'b01);
      reset = 1;
      @(negedge clk);
      chk("abort_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 6'b0);
      chk("abort_req_ready", req_ready, 0);
      reset = 0;
      cfg_w_lat = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_req_ready", req_ready, 1);
         chk("post_rst_no_resp", resp_valid, 0);
      end

      // zero-wait back-to-back read / write / read
      cfg_rdata = 32'h0000_0001;
      do_req(0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0001, 0, 0, 3, 0, acc);
      do_req(1, 32'h8000_0004, 32'h0000_0002, 4'hc, 32'h0, 0, 0, 3, 1, acc);
      cfg_rdata = 32'h0000_0003;
      do_req(0, 32'h8000_0008, 32'h0, 4'h0, 32'h0000_0003, 0, 0, 3, 1, acc);
      @(negedge clk);
      resp_ready = 0;
      chk("final_idle", req_ready, 1);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
